// File: rtl/uart_rx_push.sv
// UART 8N1 receiver that writes good bytes straight into a sync FIFO.
// Drops and flags bytes that arrive while the FIFO reports full.
module uart_rx_push #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic                  full,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  frame_err,
  output logic                  overflow,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                state_q;
  logic [1:0]            sync_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bitcnt_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  push_q;
  logic                  ferr_q;
  logic                  ovf_q;
  logic                  rxd_s;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      sh_q     <= '0;
      din_q    <= '0;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd};
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rxd_s) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_M1) begin
            cnt_q          <= '0;
            sh_q[bitcnt_q] <= rxd_s;
            if (bitcnt_q == LAST) begin
              state_q <= STOP;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_M1) begin
            cnt_q <= '0;
            if (rxd_s) begin
              state_q <= IDLE;
              if (full) begin
                ovf_q <= 1'b1;
              end else begin
                push_q <= 1'b1;
                din_q  <= sh_q;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // a held-low break must not look like a new start bit
          if (rxd_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push      = push_q;
  assign din       = din_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_push.sv
// Self-checking bench for uart_rx_push: table vectors, corner
// sequences and random frames against a frame-level model.
module tb_uart_rx_push;

  localparam int DW   = 8;
  localparam int CPB  = 16;
  localparam int H    = CPB / 2;
  // pin edge to pulse: 2 sync cycles to E, then E+H+(DW+1)*CPB+1
  localparam int LAT  = 2 + H + (DW + 1) * CPB + 1;
  localparam int HMAX = 40000;

  localparam int K_PUSH = 1;
  localparam int K_FE   = 2;
  localparam int K_OVF  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic          full;
  logic          push;
  logic [DW-1:0] din;
  logic          frame_err;
  logic          overflow;
  logic          busy;

  uart_rx_push #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .full     (full),
    .push     (push),
    .din      (din),
    .frame_err(frame_err),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [7:0]  din;
  } ev_t;

  typedef struct {
    logic [7:0]  data;
    int          stop_low;
    bit          full;
    int          kind;
    logic [7:0]  din;
  } vec_t;

  ev_t        obs[$];
  bit         busy_h[HMAX];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] model_last = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  np;
    if (cyc < HMAX) busy_h[cyc] = busy;
    if (push || frame_err || overflow) begin
      np = int'(push) + int'(frame_err) + int'(overflow);
      chk("pulse_onehot", np, 1);
      e.cyc  = cyc;
      e.kind = push ? K_PUSH : (frame_err ? K_FE : K_OVF);
      e.din  = din;
      obs.push_back(e);
    end
  end

  task automatic send_frame(input logic [7:0] data, input int stop_low,
                            output int n, output int t);
    n = cyc;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rxd = data[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_low == 0) begin
      rxd = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rxd = 1'b0;
      repeat (CPB * stop_low) @(negedge clk);
      rxd = 1'b1;
    end
    t = cyc;
  endtask

  task automatic check_frame(input int n, input int kind,
                             input logic [7:0] edin, input string nm);
    ev_t e;
    int  w;
    w = 0;
    while (obs.size() == 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (obs.size() == 0) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      e = obs.pop_front();
      chk({nm, "_kind"}, e.kind, kind);
      chk({nm, "_lat"}, e.cyc - n, LAT);
      chk({nm, "_din"}, e.din, edin);
      chk({nm, "_busy_stop"}, busy_h[n + LAT - 1], 1);
      chk({nm, "_busy_pulse"}, busy_h[n + LAT], kind == K_FE);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    int t;
    full = v.full;
    send_frame(v.data, v.stop_low, n, t);
    check_frame(n, v.kind, v.din, nm);
    full = 1'b0;
    if (v.kind == K_FE) begin
      repeat (4) @(negedge clk);
      chk({nm, "_wait_hi"}, busy_h[t + 2], 1);
      chk({nm, "_wait_exit"}, busy_h[t + 3], 0);
    end
    chk({nm, "_no_extra"}, obs.size(), 0);
    model_last = v.din;
  endtask

  vec_t tbl[6];

  initial begin
    int   n;
    int   t;
    int   n2;
    vec_t v;

    tbl[0] = '{8'hA5, 0, 1'b0, K_PUSH, 8'hA5};
    tbl[1] = '{8'h5A, 0, 1'b1, K_OVF,  8'hA5};
    tbl[2] = '{8'h77, 0, 1'b0, K_PUSH, 8'h77};
    tbl[3] = '{8'h3C, 3, 1'b0, K_FE,   8'h77};
    tbl[4] = '{8'hC3, 0, 1'b1, K_OVF,  8'h77};
    tbl[5] = '{8'h01, 0, 1'b0, K_PUSH, 8'h01};

    rst  = 1'b1;
    rxd  = 1'b1;
    full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_push", push, 0);
    chk("rst_din", din, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
      repeat (3) @(negedge clk);
    end

    // start-bit glitch: 4 clk low then high
    n = cyc;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_up", busy_h[n + 3], 1);
    chk("glitch_busy_smp", busy_h[n + 2 + H], 1);
    chk("glitch_busy_dn", busy_h[n + 3 + H], 0);
    chk("glitch_no_ev", obs.size(), 0);

    // back-to-back frames, zero idle bits
    send_frame(8'h00, 0, n, t);
    send_frame(8'hFF, 0, n2, t);
    chk("b2b_gap", n2 - n, 10 * CPB);
    check_frame(n, K_PUSH, 8'h00, "b2b0");
    check_frame(n2, K_PUSH, 8'hFF, "b2b1");
    chk("b2b_no_extra", obs.size(), 0);
    model_last = 8'hFF;
    repeat (5) @(negedge clk);

    // reset in the middle of data bit 4
    v.data = 8'hC3;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = v.data[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = v.data[4];
    repeat (H) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_push", push, 0);
    chk("mrst_din", din, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_idle", busy, 0);
    repeat (20) @(negedge clk);
    chk("mrst_no_ev", obs.size(), 0);
    model_last = 8'h00;
    run_vec('{8'h81, 0, 1'b0, K_PUSH, 8'h81}, "after_rst");

    for (int i = 0; i < 14; i++) begin
      int gap;
      v.data     = 8'($urandom);
      v.full     = ($urandom_range(0, 3) == 0);
      v.stop_low = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
      if (v.stop_low != 0) v.kind = K_FE;
      else if (v.full)     v.kind = K_OVF;
      else                 v.kind = K_PUSH;
      v.din = (v.kind == K_PUSH) ? v.data : model_last;
      run_vec(v, $sformatf("rnd%0d", i));
      gap = $urandom_range(0, 12);
      repeat (gap) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("end_no_ev", obs.size(), 0);
    chk("end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_push.md
# uart_rx_push

Serial receive front end that deserializes an asynchronous UART 8N1 line into bytes and writes each good byte into the sync FIFO. It drives the FIFO write side directly, and observes FIFO full to drop and flag bytes the FIFO cannot accept. It sits upstream of the FIFO, between the board-level RX pin and the FIFO.

## Interface
- DATA_WIDTH, 8, bits per frame; matches the FIFO data width.
- CLKS_PER_BIT, 16, clk cycles per bit period; even, minimum 4.
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line, idle high.
- full  input  1  FIFO full flag.
- push  output  1  FIFO write strobe, one-cycle pulse.
- din  output  DATA_WIDTH  byte to FIFO; registered, valid while push=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overflow  output  1  one-cycle pulse: good byte dropped because full=1.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- rxd passes through a 2-flop synchronizer to give rxd_s; both flops reset to 1. All FSM logic uses rxd_s only.
- Bit-timing counter is $clog2(CLKS_PER_BIT) bits wide, and H = CLKS_PER_BIT/2.
- A bit counter tracks 0..DATA_WIDTH-1, and a shift register assembles data LSB first.
- FSM states:
  - IDLE: on rxd_s==0, go to START and clear the counter.
  - START: count to H. Sample rxd_s: if 0, go to DATA with bit counter 0; if 1 (glitch), return to IDLE with no outputs.
  - DATA: every CLKS_PER_BIT cycles, sample rxd_s into bit[bitcnt]. After bit DATA_WIDTH-1, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxd_s and full in the same cycle.
    - rxd_s=1, full=0: load din, pulse push, go to IDLE.
    - rxd_s=1, full=1: pulse overflow, leave din unchanged, no push, go to IDLE.
    - rxd_s=0: pulse frame_err, no push, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s==1, then go to IDLE. This prevents a break condition from retriggering.
- push, frame_err and overflow are mutually exclusive; at most one fires per frame.
- din changes only on a push cycle and holds between pushes.
- push is never asserted when full was 1 in the stop-sample cycle, so the FIFO is never overrun by this block.

## Timing
- Reset values: push=0, din=0, frame_err=0, overflow=0, busy=0, FSM=IDLE, counters=0, synchronizer flops=1.
- Reset asserted mid-frame aborts the frame: no push and no flag; the FSM is in IDLE the cycle after reset deasserts.
- Define E as the first cycle in IDLE with rxd_s==0. E is 2–3 clk after the pin edge because of the synchronizer.
- busy rises in cycle E+1.
- Sample cycles:
  - start bit at E+H;
  - data bit i at E+H+(i+1)·CLKS_PER_BIT;
  - stop bit at E+H+(DATA_WIDTH+1)·CLKS_PER_BIT.
- The push, frame_err or overflow pulse is registered: high for exactly the single cycle after the stop sample, with din valid in that same cycle.
- busy falls in the same cycle the pulse is high; for frame_err, busy falls only after WAIT_HIGH exits.
- Back-to-back frames: a start bit whose falling edge immediately follows the stop bit mid-point is detected with no lost bits. The minimum gap between frames is zero idle bits.

## Test plan
- Reset, then send 0xA5 with CLKS_PER_BIT=16, full=0 -> push high for exactly one cycle at E+153, din=0xA5, no flags.
- Drive rxd low for 4 clk, then high -> START aborts at E+8, busy drops, no push, frame_err=0, overflow=0.
- Send 0x3C with the stop bit held low for 3 bit times -> frame_err pulses once and there is no push. busy stays high until rxd_s returns high, then IDLE.
- Send 0x5A with full=1 at the stop sample -> overflow pulses once, no push, din keeps the prior value. Next frame 0x77 with full=0 -> push, din=0x77.
- Send 0x00 and 0xFF back-to-back with zero idle time -> two pushes exactly 160 clk apart, din=0x00 then 0xFF.
- Assert rst during DATA bit 4 of a frame -> no push and no flags; all outputs at reset values; the next full frame 0x81 is received correctly.
